data_uart_tx: RTL and testbench
===============================

// Module: data_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter. It is a responder on the core's data-RAM port (ce/re/we/byte-valid)
//  and sits beside data_ram in the SoC, decoded by address window. Stores to TXDATA enqueue bytes into
//  a FIFO. A serializer shifts the bytes out 8N1, LSB first. Status, divisor and drop-count are readable.
// PARAMETERS
//  BASE_ADDR    32'h0000_1000  16-byte aligned window base; hit = addr[31:4]==BASE_ADDR[31:4]
//  FIFO_DEPTH   8              TX FIFO entries; power of 2, 2..128
//  DEFAULT_DIV  16'd434        reset value of BAUDDIV (clk cycles per bit)
// PORTS
//  clk         in   1   clock, all state on rising edge
//  rst         in   1   asynchronous, active-high reset
//  ce          in   1   port enable; 0 => no access, data_o=0
//  we          in   1   write strobe
//  wvalid_bit  in   4   write byte-lane mask, bit i = data_i[8i+7:8i]
//  waddr       in   32  write address
//  data_i      in   32  write data
//  re          in   1   read strobe
//  rvalid_bit  in   4   read byte-lane mask; unselected lanes of data_o read 0
//  raddr       in   32  read address
//  data_o      out  32  read data, combinational from registered state
//  txd         out  1   serial line, idle high
//  irq_idle    out  1   level: FIFO empty and serializer idle
// BEHAVIOUR
//  Register map (offset = addr[3:2]; addr[1:0] ignored):
//   0x0 TXDATA  W: if lane0 set, enqueue data_i[7:0]. R: 0.
//   0x4 STATUS  R: [0]=full [1]=empty [2]=busy [15:8]=fifo count. W: ignored.
//   0x8 BAUDDIV RW [15:0]. Lanes 0/1 write bytes. A value of 0 acts as 1.
//   0xC DROPCNT R [7:0]: saturating count of enqueues lost to full. Any write clears it.
//  Access qualification: write = ce&we&hit(waddr); read = ce&re&hit(raddr). Otherwise data_o=0 and no state change.
//  Read is zero-latency and shows pre-edge state. A same-cycle write is visible on the next cycle.
//  Reset: FIFO empty, count=0, DROPCNT=0, BAUDDIV=DEFAULT_DIV, state IDLE, txd=1, irq_idle=1, data_o=0.
//  FSM IDLE->START->DATA->STOP->IDLE; busy = state!=IDLE; each bit is held max(BAUDDIV,1) cycles:
//   IDLE : txd=1. If FIFO non-empty, pop head into shreg, latch divisor, go START (txd=0 next cycle).
//   START: after 1 bit period go DATA, bit index=0.
//   DATA : txd=shreg[idx]. After 8 periods (idx 7 done) go STOP.
//   STOP : txd=1 for 1 period, then IDLE. A queued byte starts the next cycle (one idle cycle between frames).
//  The divisor is latched at frame start. Writing BAUDDIV mid-frame affects only later frames.
//  FIFO: circular, pointers wrap at FIFO_DEPTH, count width log2(DEPTH)+1.
//   Enqueue when full with no same-cycle pop: byte dropped, DROPCNT+1 (sticks at 255).
//   Enqueue when full with a same-cycle pop: accepted, count unchanged.
//   Enqueue and pop on empty FIFO: pop is not taken this cycle (IDLE saw empty); count becomes 1.
//  DROPCNT clear and a drop in the same cycle: result is 0 (clear wins).
//  Reset mid-frame: txd returns to 1 immediately (async), FIFO contents are discarded.
//  irq_idle = empty & ~busy, derived from registered state only.
// TESTING
//  1 Reset then read 0x1004 -> data_o=32'h0000_0002, txd=1, irq_idle=1; read 0x1008 -> 434.
//  2 BAUDDIV=4, store 0x55 to 0x1000 -> txd low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each,
//    then high 4 cycles; busy=1 throughout, irq_idle=0 until STOP ends.
//  3 BAUDDIV=100, nine back-to-back stores 0x00..0x08 -> frame 0x00 starts, 8 queued (full=1),
//    count=8, DROPCNT=0. Tenth store while full -> DROPCNT=1. Write 0x100C -> 0.
//  4 Store to 0x2000 or with ce=0 -> no enqueue, STATUS unchanged, reads return 0.
//  5 Assert rst mid DATA bit -> txd=1 the same cycle, STATUS=0x2 after release; no further frame.
//  6 Write BAUDDIV 4->8 mid-frame -> current frame keeps 4-cycle bits, next frame uses 8.

Source files
------------

// File: rtl/data_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-RAM port: TXDATA enqueue FIFO,
// STATUS, BAUDDIV and saturating DROPCNT registers, LSB-first serializer.
module data_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [3:0]  wvalid_bit,
  input  logic [31:0] waddr,
  input  logic [31:0] data_i,
  input  logic        re,
  input  logic [3:0]  rvalid_bit,
  input  logic [31:0] raddr,
  output logic [31:0] data_o,
  output logic        txd,
  output logic        irq_idle
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   bauddiv, div_lat, div_lat_n, bit_cnt, bit_cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n, dropcnt, count8;
  logic          wr_hit, rd_hit, enq_req, enq, drop, pop;
  logic          full, empty, busy, bit_end;
  logic [31:0]   rd_raw, lane_mask;
  logic          unused_bits;

  assign unused_bits = &{1'b0, waddr[1:0], raddr[1:0], data_i[31:16], wvalid_bit[3:2]};

  assign wr_hit  = ce & we & (waddr[31:4] == BASE_ADDR[31:4]);
  assign rd_hit  = ce & re & (raddr[31:4] == BASE_ADDR[31:4]);

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign busy    = (state != IDLE);
  assign enq_req = wr_hit & (waddr[3:2] == 2'd0) & wvalid_bit[0];
  // A full FIFO still accepts when the serializer pops in the same cycle.
  assign enq     = enq_req & (~full | pop);
  assign drop    = enq_req & full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(enq) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= data_i[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bauddiv <= DEFAULT_DIV;
      dropcnt <= '0;
    end else begin
      if (wr_hit && waddr[3:2] == 2'd2) begin
        if (wvalid_bit[0]) bauddiv[7:0]  <= data_i[7:0];
        if (wvalid_bit[1]) bauddiv[15:8] <= data_i[15:8];
      end
      if (wr_hit && waddr[3:2] == 2'd3) dropcnt <= '0;
      else if (drop && dropcnt != '1)   dropcnt <= dropcnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      idx     <= '0;
      shreg   <= '0;
      div_lat <= 16'd1;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      idx     <= idx_n;
      shreg   <= shreg_n;
      div_lat <= div_lat_n;
    end
  end

  assign bit_end = (bit_cnt == div_lat - 16'd1);

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    idx_n     = idx;
    shreg_n   = shreg;
    div_lat_n = div_lat;
    pop       = 1'b0;
    txd       = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shreg_n   = mem[rd_ptr];
          div_lat_n = (bauddiv == '0) ? 16'd1 : bauddiv;
          bit_cnt_n = '0;
          state_n   = START;
        end
      end
      START: begin
        txd = 1'b0;
        if (bit_end) begin
          bit_cnt_n = '0;
          idx_n     = '0;
          state_n   = DATA;
        end else begin
          bit_cnt_n = bit_cnt + 16'd1;
        end
      end
      DATA: begin
        txd = shreg[idx];
        if (bit_end) begin
          bit_cnt_n = '0;
          if (idx == 3'd7) state_n = STOP;
          else             idx_n   = idx + 3'd1;
        end else begin
          bit_cnt_n = bit_cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          state_n   = IDLE;
        end else begin
          bit_cnt_n = bit_cnt + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign irq_idle = empty & ~busy;

  assign count8    = 8'(count);
  assign lane_mask = {{8{rvalid_bit[3]}}, {8{rvalid_bit[2]}},
                      {8{rvalid_bit[1]}}, {8{rvalid_bit[0]}}};

  always_comb begin
    rd_raw = '0;
    case (raddr[3:2])
      2'd1:    rd_raw = {16'd0, count8, 5'd0, busy, empty, full};
      2'd2:    rd_raw = {16'd0, bauddiv};
      2'd3:    rd_raw = {24'd0, dropcnt};
      default: rd_raw = '0;
    endcase
  end

  assign data_o = rd_hit ? (rd_raw & lane_mask) : '0;

endmodule

// File: tb/tb_data_uart_tx.sv
// Directed self-checking bench for data_uart_tx: register map, access
// qualification, frame timing, divisor latching, FIFO full/drop and async reset.
module tb_data_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce, we, re;
  logic [3:0]  wvalid_bit, rvalid_bit;
  logic [31:0] waddr, raddr, data_i, data_o;
  logic        txd, irq_idle;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  data_uart_tx #(
    .BASE_ADDR  (32'h0000_1000),
    .FIFO_DEPTH (8),
    .DEFAULT_DIV(16'd434)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .we        (we),
    .wvalid_bit(wvalid_bit),
    .waddr     (waddr),
    .data_i    (data_i),
    .re        (re),
    .rvalid_bit(rvalid_bit),
    .raddr     (raddr),
    .data_o    (data_o),
    .txd       (txd),
    .irq_idle  (irq_idle)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input logic c);
    ce = c; we = 1'b1; waddr = a; data_i = d; wvalid_bit = m;
    @(negedge clk);
    ce = 1'b0; we = 1'b0; wvalid_bit = 4'h0;
  endtask

  task automatic rdchk(input string tag, input logic [31:0] a, input logic [3:0] m,
                       input logic c, input logic r, input logic [31:0] exp);
    @(negedge clk);
    ce = c; re = r; raddr = a; rvalid_bit = m;
    #1;
    check(tag, data_o, exp);
    ce = 1'b0; re = 1'b0; rvalid_bit = 4'h0;
  endtask

  // Waits (bounded) for the start bit, then checks every cycle of the frame.
  task automatic expect_frame(input logic [7:0] b, input int unsigned div, output int unsigned waited);
    int unsigned d;
    logic        exp_bit;
    logic [2:0]  bi;
    d = (div == 0) ? 1 : div;
    waited = 0;
    while (txd !== 1'b0 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    for (int unsigned i = 0; i < 10 * d; i++) begin
      if (i < d) exp_bit = 1'b0;
      else if (i < 9 * d) begin
        bi = 3'((i - d) / d);
        exp_bit = b[bi];
      end else exp_bit = 1'b1;
      check("frame_txd", {31'd0, txd}, {31'd0, exp_bit});
      check("frame_irq_idle", {31'd0, irq_idle}, 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    int unsigned w1, w2, lows;
    rst = 1'b1; ce = 1'b0; we = 1'b0; re = 1'b0;
    wvalid_bit = 4'h0; rvalid_bit = 4'h0;
    waddr = '0; raddr = '0; data_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_irq_idle", {31'd0, irq_idle}, 32'd1);
    check("rst_data_o", data_o, 32'd0);
    rdchk("rst_status", 32'h0000_1004, 4'hF, 1'b1, 1'b1, 32'h0000_0002);
    rdchk("rst_bauddiv", 32'h0000_1008, 4'hF, 1'b1, 1'b1, 32'd434);
    rdchk("rst_dropcnt", 32'h0000_100C, 4'hF, 1'b1, 1'b1, 32'd0);
    rdchk("txdata_reads_0", 32'h0000_1000, 4'hF, 1'b1, 1'b1, 32'd0);

    // unqualified accesses and lane masks
    wr(32'h0000_2000, 32'h77, 4'hF, 1'b1);
    wr(32'h0000_1000, 32'h66, 4'hF, 1'b0);
    wr(32'h0000_1000, 32'h55, 4'b1110, 1'b1);
    wr(32'h0000_2008, 32'h5, 4'hF, 1'b1);
    wr(32'h0000_1004, 32'hFFFF_FFFF, 4'hF, 1'b1);
    rdchk("status_no_enq", 32'h0000_1004, 4'hF, 1'b1, 1'b1, 32'h0000_0002);
    check("irq_idle_no_enq", {31'd0, irq_idle}, 32'd1);
    rdchk("foreign_rd", 32'h0000_2004, 4'hF, 1'b1, 1'b1, 32'd0);
    rdchk("ce0_rd", 32'h0000_1004, 4'hF, 1'b0, 1'b1, 32'd0);
    rdchk("re0_rd", 32'h0000_1004, 4'hF, 1'b1, 1'b0, 32'd0);
    rdchk("rd_lane1_only", 32'h0000_1008, 4'b0010, 1'b1, 1'b1, 32'h0000_0100);
    wr(32'h0000_1008, 32'h0000_AB00, 4'b0010, 1'b1);
    rdchk("div_lane1_wr", 32'h0000_100B, 4'hF, 1'b1, 1'b1, 32'h0000_ABB2);

    // 0x55 at divisor 4
    wr(32'h0000_1008, 32'h0000_0004, 4'b0011, 1'b1);
    rdchk("div4", 32'h0000_1008, 4'hF, 1'b1, 1'b1, 32'd4);
    wr(32'h0000_1000, 32'h0000_0055, 4'b0001, 1'b1);
    check("enq_cycle_txd_idle", {31'd0, txd}, 32'd1);
    expect_frame(8'h55, 4, w1);
    check("start_latency_55", w1, 32'd1);
    check("irq_idle_after_55", {31'd0, irq_idle}, 32'd1);
    rdchk("status_after_55", 32'h0000_1004, 4'hF, 1'b1, 1'b1, 32'h0000_0002);

    // divisor 0 behaves as 1
    wr(32'h0000_1008, 32'h0, 4'b0011, 1'b1);
    rdchk("div0_readback", 32'h0000_1008, 4'hF, 1'b1, 1'b1, 32'd0);
    wr(32'h0000_1000, 32'h0000_000F, 4'b0001, 1'b1);
    expect_frame(8'h0F, 0, w1);
    check("start_latency_div0", w1, 32'd1);

    // divisor change mid-frame affects the next frame only
    wr(32'h0000_1008, 32'h0000_0004, 4'b0011, 1'b1);
    wr(32'h0000_1000, 32'h0000_00A5, 4'b0001, 1'b1);
    fork
      expect_frame(8'hA5, 4, w1);
      begin
        repeat (6) @(negedge clk);
        wr(32'h0000_1008, 32'h0000_0008, 4'b0011, 1'b1);
        wr(32'h0000_1000, 32'h0000_003C, 4'b0001, 1'b1);
      end
    join
    check("start_latency_a5", w1, 32'd1);
    expect_frame(8'h3C, 8, w2);
    check("idle_gap_before_3c", w2, 32'd1);

    // FIFO fill, drop counting and saturation
    wr(32'h0000_1008, 32'd100, 4'b0011, 1'b1);
    for (int unsigned i = 0; i < 9; i++) wr(32'h0000_1000, i, 4'b0001, 1'b1);
    rdchk("status_full", 32'h0000_1004, 4'hF, 1'b1, 1'b1, 32'h0000_0805);
    rdchk("dropcnt_0", 32'h0000_100C, 4'hF, 1'b1, 1'b1, 32'd0);
    wr(32'h0000_1000, 32'h0000_0099, 4'b0001, 1'b1);
    rdchk("dropcnt_1", 32'h0000_100C, 4'hF, 1'b1, 1'b1, 32'd1);
    rdchk("status_still_full", 32'h0000_1004, 4'hF, 1'b1, 1'b1, 32'h0000_0805);
    for (int unsigned i = 0; i < 258; i++) wr(32'h0000_1000, 32'h0000_0011, 4'b0001, 1'b1);
    rdchk("dropcnt_sat", 32'h0000_100C, 4'hF, 1'b1, 1'b1, 32'd255);
    wr(32'h0000_100C, 32'h0, 4'b0001, 1'b1);
    rdchk("dropcnt_clear", 32'h0000_100C, 4'hF, 1'b1, 1'b1, 32'd0);

    // async reset in the middle of a DATA bit of frame 0x00
    @(negedge clk);
    check("txd_mid_data", {31'd0, txd}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("txd_async_rst", {31'd0, txd}, 32'd1);
    check("irq_idle_async_rst", {31'd0, irq_idle}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    rdchk("status_after_rst", 32'h0000_1004, 4'hF, 1'b1, 1'b1, 32'h0000_0002);
    rdchk("div_after_rst", 32'h0000_1008, 4'hF, 1'b1, 1'b1, 32'd434);
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check("no_frame_after_rst", lows, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
